issue_rename_stage: RTL and testbench
=====================================

Name: issue_rename_stage

Overview:
- Parametrised Tomasulo issue stage: decodes one instruction per cycle, reads operands from an internal register file, renames them through a register status table (tag per architectural register), and forwards CDB results.
- Hands a registered issue packet to the reservation stations over a valid/ready handshake.
- Sits between instruction fetch and the reservation-station bank; snoops the common data bus (CDB).

Parameters:
- XLEN, 32, data width of registers, operands and CDB.
- NREG, 32, architectural register count. Register 0 is hard-wired to zero.
- TAG_W, 4, reservation-station tag width. Tag 0 is reserved and means "value ready".
- NUM_CLASS, 3, functional-unit classes: 0=ALU, 1=LOAD, 2=STORE.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage accepts instruction this cycle
- in_ins  in  32  MIPS-format instruction
- alloc_avail  in  NUM_CLASS  per-class free-RS-entry available
- alloc_tag  in  NUM_CLASS*TAG_W  per-class free tag offered (slice c = class c)
- alloc_take  out  NUM_CLASS  one-hot, pulses on the accept cycle to consume the tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcasting tag
- cdb_data  in  XLEN  broadcast result
- out_valid  out  1  issue packet valid
- out_ready  in  1  RS bank accepts packet
- out_class  out  NUM_CLASS  one-hot target class
- out_func  out  6  func field (ALU), else 0
- out_tag  out  TAG_W  tag assigned to this instruction
- out_label1 / out_label2  out  TAG_W  producer tag, 0 if value valid
- out_value1 / out_value2  out  XLEN  operand values
- out_imm  out  XLEN  sign-extended imm16
- illegal  out  1  one-cycle pulse when an unsupported opcode is dropped

Behaviour:
- Reset: every status label is 0, every register is 0, out_valid=0, illegal=0, and all other outputs are 0. Reset mid-packet discards the packet.
- Decode, by opcode ins[31:26]:
  - 0x00 R-type: ALU; src1=rs, src2=rt, dest=rd.
  - 0x08 addi: ALU; src1=rs, operand2 = sign-extended imm with label 0, dest=rt.
  - 0x23 lw: LOAD; src1=rs, dest=rt.
  - 0x2B sw: STORE; src1=rs, src2=rt, no dest.
  - Any other opcode: accepted and dropped, illegal pulses, no tag is taken, status is unchanged.
- in_ready = (!out_valid || out_ready) && alloc_avail[class of in_ins]. Illegal opcodes ignore alloc_avail.
- Accept = in_valid && in_ready.
  - The packet is registered with a latency of 1 cycle: out_* become valid the cycle after accept.
  - alloc_take[class] is asserted combinationally on the accept cycle.
  - status[dest] <= alloc_tag[class] at the clock edge, unless dest=0.
- Operand read, per source register r:
  - r=0: label 0, value 0.
  - Otherwise, if status[r]!=0 and cdb_valid and cdb_tag==status[r]: label 0, value cdb_data (same-cycle bypass).
  - Otherwise: label status[r], value regfile[r].
- CDB write: when cdb_valid, for every r with status[r]==cdb_tag (and status[r]!=0), regfile[r] <= cdb_data and status[r] <= 0.
- Simultaneous CDB clear and issue rename of the same register: the issue's new tag wins; regfile is still written.
- Source equals dest (e.g. add r3,r3,r1): operands read the old mapping; the rename applies after the edge.
- Packet hold: while out_valid && !out_ready, all out_* stay stable (except as permitted under the optional feature below), and no new instruction is accepted.
- Back-to-back: when out_ready=1, one instruction is accepted per cycle.
- cdb_tag=0 with cdb_valid=1 has no effect.

Optional Feature:
- ISSUE_CDB_SNOOP_EN defined: while a packet is held, if cdb_valid and cdb_tag equals a nonzero out_labelN, then out_valueN <= cdb_data and out_labelN <= 0 at the next edge.
- Not defined: held operands are frozen, and the RS bank must snoop the CDB on capture.

Test Plan:
- Reset → out_valid=0; reading r5 after reset gives label 0, value 0.
- add r3,r1,r2 with alloc_tag[ALU]=4 → next cycle out_tag=4, labels 0; then sub r6,r3,r1 → out_label1=4.
- After the above, cdb_valid, tag 4, data 0x55 in the same cycle as issuing or r7,r3,r0 → out_label1=0, out_value1=0x55; status[r3]=0 and regfile[r3]=0x55.
- CDB tag 4 and issue of new dest r3 with tag 5 in the same cycle → status[r3]=5.
- out_ready=0 for 3 cycles with a held packet label2=6, then CDB tag 6 data 0x99 → with macro: label2=0, value2=0x99; without: unchanged. in_ready=0 throughout.
- opcode 0x3F → illegal pulses once, no alloc_take, out_valid stays 0; alloc_avail[LOAD]=0 with lw → in_ready=0.

Source files
------------

// File: rtl/issue_rename_stage.sv
// Purpose : Tomasulo issue/rename stage. Decodes one MIPS instruction per cycle, reads
//           operands from the register file, renames its destination through the status table and forwards CDB results.
// Latency : 1 cycle from accept to out_valid. Backpressure: a held packet (out_valid && !out_ready) blocks new accepts.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_ins      instruction handshake and instruction word
//   alloc_avail/alloc_tag         per-class free RS entry and the free tag it offers
//   alloc_take                    one-hot, combinational on the accept cycle; consumes the offered tag
//   cdb_valid/cdb_tag/cdb_data    common data bus snoop
//   out_valid/out_ready           issue packet handshake towards the RS bank
//   out_class/out_func/out_tag    one-hot class, ALU func field, assigned tag
//   out_label1/2, out_value1/2    operand producer tags (0 = value ready) and values
//   out_imm                       sign-extended imm16
//   illegal                       one-cycle pulse, the cycle after an unsupported opcode is dropped
//
// Build option: define ISSUE_CDB_SNOOP_EN so that a held packet captures CDB results into its
// operands. Without it, held operands stay frozen and the RS bank must snoop on capture.
module issue_rename_stage #(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int TAG_W     = 4,
   parameter int NUM_CLASS = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_ins,
   input  logic [NUM_CLASS-1:0]       alloc_avail,
   input  logic [NUM_CLASS*TAG_W-1:0] alloc_tag,
   output logic [NUM_CLASS-1:0]       alloc_take,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [XLEN-1:0]            cdb_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CLASS-1:0]       out_class,
   output logic [5:0]                 out_func,
   output logic [TAG_W-1:0]           out_tag,
   output logic [TAG_W-1:0]           out_label1,
   output logic [TAG_W-1:0]           out_label2,
   output logic [XLEN-1:0]            out_value1,
   output logic [XLEN-1:0]            out_value2,
   output logic [XLEN-1:0]            out_imm,
   output logic                       illegal
);

   localparam int CW        = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
   localparam int CLS_ALU   = 0;
   localparam int CLS_LOAD  = 1;
   localparam int CLS_STORE = 2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic [NUM_CLASS-1:0] cls;
      logic [5:0]           func;
      logic [TAG_W-1:0]     tag;
      logic [TAG_W-1:0]     label1;
      logic [TAG_W-1:0]     label2;
      logic [XLEN-1:0]      value1;
      logic [XLEN-1:0]      value2;
      logic [XLEN-1:0]      imm;
   } pkt_t;

   typedef struct packed {
      logic [TAG_W-1:0] label;
      logic [XLEN-1:0]  value;
   } opnd_t;

   // Architectural state: producer tag per register (0 = value in regfile) and the values.
   logic [TAG_W-1:0] status_q  [NREG];
   logic [TAG_W-1:0] status_d  [NREG];
   logic [XLEN-1:0]  regfile_q [NREG];
   logic [XLEN-1:0]  regfile_d [NREG];

   pkt_t pkt_q, pkt_d, new_pkt;
   logic out_valid_q, out_valid_d;
   logic illegal_q, illegal_d;

   // Decode
   logic [5:0]       opcode;
   logic [4:0]       rs, rt, rd;
   logic [XLEN-1:0]  imm_sext;
   logic [CW-1:0]    cls_idx;
   logic             is_legal, has_dest, has_src2, use_imm2;
   logic [4:0]       dest, src2;
   logic [TAG_W-1:0] new_tag;
   logic             stage_free, accept, rename_en;
   opnd_t            opnd1, opnd2;

   assign opcode   = in_ins[31:26];
   assign rs       = in_ins[25:21];
   assign rt       = in_ins[20:16];
   assign rd       = in_ins[15:11];
   assign imm_sext = {{(XLEN-16){in_ins[15]}}, in_ins[15:0]};

   always_comb begin
      cls_idx  = CW'(CLS_ALU);
      is_legal = 1'b1;
      has_dest = 1'b0;
      has_src2 = 1'b0;
      use_imm2 = 1'b0;
      dest     = 5'd0;
      src2     = 5'd0;
      unique case (opcode)
         OP_RTYPE: begin
            has_src2 = 1'b1;
            src2     = rt;
            has_dest = 1'b1;
            dest     = rd;
         end
         OP_ADDI: begin
            use_imm2 = 1'b1;
            has_dest = 1'b1;
            dest     = rt;
         end
         OP_LW: begin
            cls_idx  = CW'(CLS_LOAD);
            has_dest = 1'b1;
            dest     = rt;
         end
         OP_SW: begin
            cls_idx  = CW'(CLS_STORE);
            has_src2 = 1'b1;
            src2     = rt;
         end
         default: is_legal = 1'b0;
      endcase
   end

   // Operand read with same-cycle CDB bypass; r0 always reads as a ready zero.
   function automatic opnd_t read_opnd(input logic [4:0] r);
      opnd_t o;
      o = '0;
      if (r != 5'd0 && int'(r) < NREG) begin
         if (status_q[r] != '0 && cdb_valid && cdb_tag == status_q[r]) begin
            o.value = cdb_data;
         end else begin
            o.label = status_q[r];
            o.value = regfile_q[r];
         end
      end
      return o;
   endfunction

   always_comb begin
      opnd1 = read_opnd(rs);
      opnd2 = has_src2 ? read_opnd(src2) : opnd_t'('0);
   end

   // Illegal opcodes are swallowed without needing an RS entry.
   assign stage_free = !out_valid_q || out_ready;
   assign in_ready   = stage_free && (is_legal ? alloc_avail[cls_idx] : 1'b1);
   assign accept     = in_valid && in_ready;
   assign new_tag    = alloc_tag[cls_idx*TAG_W +: TAG_W];
   assign rename_en  = accept && is_legal && has_dest && dest != 5'd0;

   always_comb begin
      alloc_take = '0;
      if (accept && is_legal) alloc_take[cls_idx] = 1'b1;
   end

   always_comb begin
      new_pkt              = '0;
      new_pkt.cls[cls_idx] = 1'b1;
      new_pkt.func         = (opcode == OP_RTYPE) ? in_ins[5:0] : 6'd0;
      new_pkt.tag          = new_tag;
      new_pkt.label1       = opnd1.label;
      new_pkt.value1       = opnd1.value;
      new_pkt.label2       = use_imm2 ? '0 : opnd2.label;
      new_pkt.value2       = use_imm2 ? imm_sext : opnd2.value;
      new_pkt.imm          = imm_sext;
   end

   // Status/regfile update. The rename is applied after the CDB clear so that a
   // same-cycle rename of a completing register keeps the new tag.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         status_d[r]  = status_q[r];
         regfile_d[r] = regfile_q[r];
         if (r != 0 && cdb_valid && cdb_tag != '0 && status_q[r] == cdb_tag) begin
            regfile_d[r] = cdb_data;
            status_d[r]  = '0;
         end
         if (rename_en && int'(dest) == r) status_d[r] = new_tag;
      end
   end

   // Packet register
   always_comb begin
      out_valid_d = out_valid_q;
      pkt_d       = pkt_q;
      illegal_d   = accept && !is_legal;
      if (stage_free) begin
         out_valid_d = accept && is_legal;
         if (accept && is_legal) pkt_d = new_pkt;
      end
`ifdef ISSUE_CDB_SNOOP_EN
      else if (cdb_valid && cdb_tag != '0) begin
         if (pkt_q.label1 == cdb_tag) begin
            pkt_d.label1 = '0;
            pkt_d.value1 = cdb_data;
         end
         if (pkt_q.label2 == cdb_tag) begin
            pkt_d.label2 = '0;
            pkt_d.value2 = cdb_data;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            status_q[r]  <= '0;
            regfile_q[r] <= '0;
         end
         pkt_q       <= '0;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            status_q[r]  <= status_d[r];
            regfile_q[r] <= regfile_d[r];
         end
         pkt_q       <= pkt_d;
         out_valid_q <= out_valid_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_class  = pkt_q.cls;
   assign out_func   = pkt_q.func;
   assign out_tag    = pkt_q.tag;
   assign out_label1 = pkt_q.label1;
   assign out_label2 = pkt_q.label2;
   assign out_value1 = pkt_q.value1;
   assign out_value2 = pkt_q.value2;
   assign out_imm    = pkt_q.imm;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_issue_rename_stage.sv
// Purpose : bench for issue_rename_stage; directed instructions, expected packets queued at issue.
// Latency : a negedge monitor pops and compares each packet on its out_valid && out_ready cycle.
// Backpressure: out_ready is dropped by the stimulus to hold a packet and observe in_ready.
module tb_issue_rename_stage;
   localparam int XLEN = 32, NREG = 32, TAG_W = 4, NUM_CLASS = 3;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       in_valid, in_ready;
   logic [31:0]                in_ins;
   logic [NUM_CLASS-1:0]       alloc_avail, alloc_take;
   logic [NUM_CLASS*TAG_W-1:0] alloc_tag;
   logic                       cdb_valid;
   logic [TAG_W-1:0]           cdb_tag;
   logic [XLEN-1:0]            cdb_data;
   logic                       out_valid, out_ready;
   logic [NUM_CLASS-1:0]       out_class;
   logic [5:0]                 out_func;
   logic [TAG_W-1:0]           out_tag, out_label1, out_label2;
   logic [XLEN-1:0]            out_value1, out_value2, out_imm;
   logic                       illegal;

   issue_rename_stage #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NUM_CLASS(NUM_CLASS)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
      .alloc_avail(alloc_avail), .alloc_tag(alloc_tag), .alloc_take(alloc_take),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_func(out_func), .out_tag(out_tag),
      .out_label1(out_label1), .out_label2(out_label2),
      .out_value1(out_value1), .out_value2(out_value2), .out_imm(out_imm),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  cls;
      logic [5:0]  func;
      logic [3:0]  tag;
      logic [3:0]  l1;
      logic [3:0]  l2;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e, mon_a;
   int   checks = 0;
   int   failures = 0;

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] sx(input logic [31:0] ins);
      return {{16{ins[15]}}, ins[15:0]};
   endfunction

   function automatic exp_t mk(input int cls, input int fn, input int tag, input int l1,
                               input int v1, input int l2, input int v2, input logic [31:0] imm);
      exp_t e;
      e.cls = 3'(cls); e.func = 6'(fn); e.tag = 4'(tag);
      e.l1 = 4'(l1); e.v1 = 32'(v1); e.l2 = 4'(l2); e.v2 = 32'(v2); e.imm = imm;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_tags(input int alu, input int ld, input int st);
      alloc_tag = {4'(st), 4'(ld), 4'(alu)};
   endtask

   // Present one instruction for one cycle; it must be accepted with the given take pattern.
   task automatic issue(input logic [31:0] ins, input logic [2:0] take_exp, input string name);
      in_ins   = ins;
      in_valid = 1'b1;
      @(negedge clk);
      chk({name, "_in_ready"}, 64'(in_ready), 64'(1));
      chk({name, "_take"}, 64'(alloc_take), 64'(take_exp));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         mon_a = {out_class, out_func, out_tag, out_label1, out_label2, out_value1, out_value2, out_imm};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pkt_unexpected: got %h expected none", mon_a);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a !== mon_e) begin
               failures++;
               $display("FAIL pkt: got cls=%h func=%h tag=%h l1=%h l2=%h v1=%h v2=%h imm=%h expected cls=%h func=%h tag=%h l1=%h l2=%h v1=%h v2=%h imm=%h",
                        mon_a.cls, mon_a.func, mon_a.tag, mon_a.l1, mon_a.l2, mon_a.v1, mon_a.v2, mon_a.imm,
                        mon_e.cls, mon_e.func, mon_e.tag, mon_e.l1, mon_e.l2, mon_e.v1, mon_e.v2, mon_e.imm);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ins;
      rst_n = 1'b0; in_valid = 1'b0; in_ins = '0; alloc_avail = 3'b111; alloc_tag = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; out_ready = 1'b1;

      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_illegal",   64'(illegal),   64'(0));
      chk("rst_out_tag",   64'(out_tag),   64'(0));
      chk("rst_value1",    64'(out_value1), 64'(0));
      chk("rst_class",     64'(out_class), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // add r4,r5,r5: r5 reads as ready zero after reset
      ins = rtype(5, 5, 4, 'h20); set_tags(2, 1, 1);
      exp_q.push_back(mk(1, 'h20, 2, 0, 0, 0, 0, sx(ins)));
      issue(ins, 3'b001, "add_r4");
      // add r3,r1,r2 tag 4 (back-to-back)
      ins = rtype(1, 2, 3, 'h20); set_tags(4, 1, 1);
      exp_q.push_back(mk(1, 'h20, 4, 0, 0, 0, 0, sx(ins)));
      issue(ins, 3'b001, "add_r3");
      // sub r6,r3,r1: r3 now waits on tag 4
      ins = rtype(3, 1, 6, 'h22); set_tags(5, 1, 1);
      exp_q.push_back(mk(1, 'h22, 5, 4, 0, 0, 0, sx(ins)));
      issue(ins, 3'b001, "sub_r6");
      // or r7,r3,r0 with CDB tag 4 = 0x55 in the same cycle: bypass
      ins = rtype(3, 0, 7, 'h25); set_tags(7, 1, 1);
      cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_data = 32'h55;
      exp_q.push_back(mk(1, 'h25, 7, 0, 'h55, 0, 0, sx(ins)));
      issue(ins, 3'b001, "or_r7");
      cdb_valid = 1'b0;
      // add r8,r3,r6: r3 now committed 0x55, r6 waits on tag 5
      ins = rtype(3, 6, 8, 'h20); set_tags(8, 1, 1);
      exp_q.push_back(mk(1, 'h20, 8, 0, 'h55, 5, 0, sx(ins)));
      issue(ins, 3'b001, "add_r8");
      // add r3,r0,r0 tag 9, then add r3,r3,r0 tag 10 while CDB completes tag 9
      ins = rtype(0, 0, 3, 'h20); set_tags(9, 1, 1);
      exp_q.push_back(mk(1, 'h20, 9, 0, 0, 0, 0, sx(ins)));
      issue(ins, 3'b001, "add_r3_t9");
      ins = rtype(3, 0, 3, 'h20); set_tags(10, 1, 1);
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h66;
      exp_q.push_back(mk(1, 'h20, 10, 0, 'h66, 0, 0, sx(ins)));
      issue(ins, 3'b001, "add_r3_t10");
      cdb_valid = 1'b0;
      // add r9,r3,r3: new tag 10 won, but regfile got 0x66
      ins = rtype(3, 3, 9, 'h20); set_tags(11, 1, 1);
      exp_q.push_back(mk(1, 'h20, 11, 10, 'h66, 10, 'h66, sx(ins)));
      issue(ins, 3'b001, "add_r9");
      // add r10,r0,r0 tag 6; sw r10,16(r1) tag 12 on the STORE class
      ins = rtype(0, 0, 10, 'h20); set_tags(6, 1, 1);
      exp_q.push_back(mk(1, 'h20, 6, 0, 0, 0, 0, sx(ins)));
      issue(ins, 3'b001, "add_r10");
      ins = itype('h2B, 1, 10, 16); set_tags(1, 1, 12);
`ifdef ISSUE_CDB_SNOOP_EN
      exp_q.push_back(mk(4, 0, 12, 0, 0, 0, 'h99, 32'h10));
`else
      exp_q.push_back(mk(4, 0, 12, 0, 0, 6, 0, 32'h10));
`endif
      issue(ins, 3'b100, "sw");

      // Hold the sw packet with addi r11,r10,-2 waiting at the input
      out_ready = 1'b0;
      ins = itype('h08, 10, 11, 'hFFFE); set_tags(13, 1, 1);
      in_ins = ins; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_in_ready", 64'(in_ready),   64'(0));
         chk("hold_valid",    64'(out_valid),  64'(1));
         chk("hold_label2",   64'(out_label2), 64'(6));
         chk("hold_take",     64'(alloc_take), 64'(0));
         @(posedge clk); #1;
      end
      cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h99;
      @(negedge clk);
      chk("hold_cdb_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      cdb_valid = 1'b0; out_ready = 1'b1;
      exp_q.push_back(mk(1, 0, 13, 0, 'h99, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE));
      @(negedge clk);
      chk("addi_in_ready", 64'(in_ready),   64'(1));
      chk("addi_take",     64'(alloc_take), 64'(1));
      @(posedge clk); #1;

      // Illegal opcode: accepted even with no RS entry free, takes no tag
      in_ins = itype('h3F, 1, 2, 0); in_valid = 1'b1; alloc_avail = 3'b000;
      @(negedge clk);
      chk("ill_in_ready", 64'(in_ready),   64'(1));
      chk("ill_take",     64'(alloc_take), 64'(0));
      @(posedge clk); #1;
      ins = itype('h23, 11, 12, 4); in_ins = ins; alloc_avail = 3'b101; set_tags(1, 3, 1);
      @(negedge clk);
      chk("ill_pulse",       64'(illegal),    64'(1));
      chk("ill_no_pkt",      64'(out_valid),  64'(0));
      chk("lw_noavail_rdy",  64'(in_ready),   64'(0));
      chk("lw_noavail_take", 64'(alloc_take), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("ill_pulse_end", 64'(illegal),   64'(0));
      chk("ill_no_pkt2",   64'(out_valid), 64'(0));
      @(posedge clk); #1;
      // lw r12,4(r11): r11 waits on addi tag 13
      alloc_avail = 3'b111;
      exp_q.push_back(mk(2, 0, 3, 13, 0, 0, 0, 32'h4));
      issue(ins, 3'b010, "lw");
      @(negedge clk);
      @(posedge clk); #1;

      // Reset while a packet is held discards it and clears the status table
      out_ready = 1'b0;
      ins = rtype(0, 0, 13, 'h20); set_tags(14, 1, 1);
      issue(ins, 3'b001, "add_r13");
      @(negedge clk);
      chk("pre_rst_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_tag",   64'(out_tag),   64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      ins = rtype(13, 0, 14, 'h20); set_tags(15, 1, 1);
      exp_q.push_back(mk(1, 'h20, 15, 0, 0, 0, 0, sx(ins)));
      issue(ins, 3'b001, "add_r14");

      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
